// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the bytecode prefetch unit: the fetch
//                FSM state encoding, the default geometry and the FIFO entry
//                layout ({data, pc}) at that default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_FIFO_DEPTH    = 4;

    // IDLE : no read outstanding
    // REQ  : read issued, waiting for mem_ready, result will be buffered
    // DRAIN: read issued before a redirect, result will be discarded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]    data;
        logic [DEF_ADDRESS_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Synchronous FIFO with push, pop, flush and occupancy level.
//                Flush dominates push and pop. The head output reads zero
//                while the FIFO is empty.
//  Ports       : clk, rst (sync, active-high)
//                i_flush, i_push, i_push_data, i_pop
//                o_head_valid, o_head_data, o_level
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
    parameter  int WIDTH   = 16,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic               o_head_valid,
    output logic [WIDTH-1:0]   o_head_data,
    output logic [LEVEL_W-1:0] o_level
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q,  count_d;
    logic               w_do_pop;

    assign o_head_valid = (count_q != '0);
    assign o_head_data  = o_head_valid ? mem_q[rd_ptr_q] : '0;
    assign o_level      = count_q;
    assign w_do_pop     = i_pop & o_head_valid;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + LEVEL_W'(i_push) - LEVEL_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bytecode_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bytecode_prefetch_unit
//  Description : Fetch PC holder and single-outstanding byte reader feeding a
//                prefetch FIFO; delivers {byte, pc} to the decoder. Branch
//                redirect flushes the FIFO and discards any stale read.
//  Ports       : clk, reset (sync, active-high), run
//                redirect_valid, redirect_pc
//                mem_address, mem_start (out) / mem_ready, mem_data (in)
//                byte_valid, byte_data, byte_pc (out) / byte_ready (in)
//                level, fault (out)
//  Options     : FETCH_BOUNDS_CHECK_EN - adds PC_LIMIT; a request for a PC
//                above PC_LIMIT is suppressed and raises sticky fault.
//                Without it the PC wraps and fault stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bytecode_prefetch_unit
    import fetch_pkg::*;
#(
    parameter  int                     ADDRESS_WIDTH = 8,
    parameter  int                     DATA_WIDTH    = 8,
    parameter  int                     FIFO_DEPTH    = 4,
    parameter  logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
`ifdef FETCH_BOUNDS_CHECK_EN
    parameter  logic [ADDRESS_WIDTH-1:0] PC_LIMIT    = '1,
`endif
    localparam int                     LEVEL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_start,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     byte_valid,
    output logic [DATA_WIDTH-1:0]    byte_data,
    output logic [ADDRESS_WIDTH-1:0] byte_pc,
    input  logic                     byte_ready,
    output logic [LEVEL_W-1:0]       level,
    output logic                     fault
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [ADDRESS_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the outstanding read; kept apart from fetch_pc so a
    // redirect during DRAIN cannot disturb mem_address.
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     fault_q, fault_d;

    logic                     w_push;
    logic                     w_pop;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;
    logic [LEVEL_W-1:0]       w_level_after;
    logic                     w_room_now;
    logic                     w_room_after;
    logic                     w_fetch_oor;
    logic                     w_next_oor;
    logic                     w_redirect_oor;
    entry_t                   w_push_entry;
    entry_t                   w_head_entry;

    assign w_push        = (state_q == ST_REQ) & mem_ready & ~redirect_valid;
    assign w_pop         = byte_valid & byte_ready & ~redirect_valid;
    assign w_next_pc     = addr_q + ADDRESS_WIDTH'(1);
    assign w_level_after = level + LEVEL_W'(w_push) - LEVEL_W'(w_pop);
    // With one read in flight at most, level < depth guarantees its slot.
    assign w_room_now    = (level < LEVEL_W'(FIFO_DEPTH));
    assign w_room_after  = (w_level_after < LEVEL_W'(FIFO_DEPTH));

`ifdef FETCH_BOUNDS_CHECK_EN
    assign w_fetch_oor    = (fetch_pc_q  > PC_LIMIT);
    assign w_next_oor     = (w_next_pc   > PC_LIMIT);
    assign w_redirect_oor = (redirect_pc > PC_LIMIT);
`else
    assign w_fetch_oor    = 1'b0;
    assign w_next_oor     = 1'b0;
    assign w_redirect_oor = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        fault_d    = fault_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            fault_d    = fault_q & w_redirect_oor;
        end

        case (state_q)
            ST_IDLE: begin
                if (!redirect_valid && run && w_room_now) begin
                    if (w_fetch_oor) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = fetch_pc_q;
                    end
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    // Data arriving with the redirect is simply dropped.
                    state_d = mem_ready ? ST_IDLE : ST_DRAIN;
                end else if (mem_ready) begin
                    fetch_pc_d = w_next_pc;
                    if (run && w_room_after) begin
                        if (w_next_oor) begin
                            fault_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            addr_d = w_next_pc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
        end
    end

    assign mem_start    = (state_q != ST_IDLE);
    assign mem_address  = addr_q;
    assign fault        = fault_q;
    assign w_push_entry = '{data: mem_data, pc: addr_q};
    assign byte_data    = w_head_entry.data;
    assign byte_pc      = w_head_entry.pc;

    prefetch_fifo #(
        .WIDTH (DATA_WIDTH + ADDRESS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_pop),
        .o_head_valid (byte_valid),
        .o_head_data  (w_head_entry),
        .o_level      (level)
    );

endmodule
`default_nettype wire

// File: doc/bytecode_prefetch_unit.md
Name: bytecode_prefetch_unit

Overview:
Parametrised successor to the single-byte program-counter fetcher. Holds a fetch PC, issues byte reads to the bytecode memory with a start/ready handshake, and buffers results in a small prefetch FIFO. Presents bytes to the JVM decode stage with a valid/ready handshake, tagged with their PC. Supports branch redirect with flush and discard of stale in-flight reads; sits between bytecode memory and the decoder.

Parameters:
ADDRESS_WIDTH, 8, width of bytecode PC and memory address
DATA_WIDTH, 8, width of one fetched unit (bytecode byte)
FIFO_DEPTH, 4, prefetch entries; power of two, >=2
RESET_PC, 0, fetch PC value loaded by reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
run  in  1  1 = fetching permitted; 0 = no new requests (in-flight read still completes)
redirect_valid  in  1  one-cycle pulse: jump to redirect_pc and flush
redirect_pc  in  ADDRESS_WIDTH  new fetch PC
mem_address  out  ADDRESS_WIDTH  read address, stable while mem_start high
mem_start  out  1  read request, held until mem_ready
mem_ready  in  1  read data valid this cycle
mem_data  in  DATA_WIDTH  read data
byte_valid  out  1  FIFO head valid
byte_data  out  DATA_WIDTH  FIFO head data
byte_pc  out  ADDRESS_WIDTH  PC of FIFO head
byte_ready  in  1  decoder accepts head when byte_valid & byte_ready
level  out  clog2(FIFO_DEPTH)+1  buffered entry count
fault  out  1  fetch PC out of bounds (optional feature only; else tied 0)

Behaviour:
- Reset (any state, mid-read included): fetch_pc=RESET_PC, mem_start=0, mem_address=RESET_PC, byte_valid=0, byte_data=0, byte_pc=0, level=0, fault=0, state=IDLE. A mem_ready arriving in the reset cycle is ignored.
- States: IDLE (no read outstanding), REQ (mem_start=1, waiting), DRAIN (stale read outstanding after redirect, mem_start=1 held until mem_ready).
- IDLE->REQ when run=1, no redirect and level < FIFO_DEPTH; one read outstanding maximum; mem_address=fetch_pc.
- REQ on mem_ready: write {mem_data, mem_address} to FIFO, fetch_pc+1 (wraps modulo 2^ADDRESS_WIDTH), -> REQ again if run=1 and level after this cycle's push/pop < FIFO_DEPTH, else IDLE. Back-to-back throughput 1 byte/cycle when memory has 1-cycle ready.
- Slot reservation: a request is only issued if a FIFO slot is guaranteed; FIFO never overflows, mem_ready never back-pressured.
- Pop: byte_valid & byte_ready removes head next edge; push and pop in same cycle leave level unchanged. Push into empty FIFO: byte_valid asserts the cycle after mem_ready (1-cycle latency).
- Redirect (highest priority): FIFO flushed (level=0, byte_valid=0 next cycle), fetch_pc=redirect_pc. Any pop in the same cycle is discarded. If state REQ and mem_ready=0 -> DRAIN; if mem_ready=1 in the same cycle, data is dropped -> IDLE. IDLE -> IDLE.
- DRAIN on mem_ready: data dropped, -> IDLE. Further redirects in DRAIN only update fetch_pc.
- run=0: current read finishes normally; no new request.

Optional Feature:
FETCH_BOUNDS_CHECK_EN: adds parameter PC_LIMIT (default 2^ADDRESS_WIDTH-1). If fetch_pc > PC_LIMIT when a request would issue, no request is made, fault=1 (sticky until reset or redirect to an in-range PC). Without macro: no check, PC wraps, fault tied 0.

Decomposition:
- Shared package fetch_pkg: state encoding (IDLE/REQ/DRAIN), FIFO entry struct {data, pc}, default widths.
- One sub-module, prefetch_fifo: synchronous FIFO with push/pop/flush and level; parent owns FSM and PC.

Test Plan:
- Reset, run=1, memory ready 1 cycle after start, mem[i]=i+0x10, byte_ready=1 -> bytes 0x10,0x11,0x12... with byte_pc 0,1,2 consecutive, no gaps after first.
- byte_ready=0, run=1 -> exactly FIFO_DEPTH=4 reads, level=4, mem_start=0; then one pop -> exactly one new read.
- Redirect to 0x40 while REQ waiting (ready delayed 3 cycles) -> stale byte dropped, FIFO empty, next delivered byte has byte_pc=0x40.
- Redirect coincident with mem_ready and pop -> neither byte enters FIFO, level=0, next fetch at redirect_pc.
- fetch_pc=0xFF with ADDRESS_WIDTH=8 -> next byte_pc 0x00 (wrap); with FETCH_BOUNDS_CHECK_EN, PC_LIMIT=0x7F, PC reaching 0x80 -> fault=1, no mem_start.
- Reset asserted in DRAIN with mem_ready same cycle -> all outputs reset values, level=0, fetch restarts at RESET_PC.
